// File: rtl/wm8731_i2c_responder.sv
// wm8731_i2c_responder: oversampled I2C write target holding the WM8731 control register file
module wm8731_i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_reg_wr,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_bad_reg,
  output logic       o_soft_rst,
  output logic       o_busy,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data
);
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, ACK_A = 3'd2, BYTE1 = 3'd3,
                         ACK_1 = 3'd4, BYTE2 = 3'd5, ACK_2 = 3'd6, IGNORE = 3'd7;
  localparam logic [89:0] DEFAULTS = {9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
                                      9'h00A, 9'h079, 9'h079, 9'h097, 9'h097};
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop, shifting, addr_ok;
  logic [2:0] state, cnt;
  logic done, data_hi;
  logic [7:0] shreg, data_lo;
  logic [6:0] reg_a;
  logic [8:0] regs [10];
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start = scl_s & sda_d & ~sda_s;
  assign stop = scl_s & ~sda_d & sda_s;
  assign shifting = (state == ADDR) | (state == BYTE1) | (state == BYTE2);
  assign addr_ok = shreg == {DEV_ADDR, 1'b0};
  assign o_rd_data = (i_rd_addr < 4'd10) ? regs[i_rd_addr] : 9'd0;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
      shreg <= '0;
      data_lo <= '0;
      data_hi <= 1'b0;
      reg_a <= '0;
      o_sda_oe <= 1'b0;
      o_reg_wr <= 1'b0;
      o_bad_reg <= 1'b0;
      o_soft_rst <= 1'b0;
      o_busy <= 1'b0;
      o_reg_addr <= '0;
      o_reg_data <= '0;
      for (int i = 0; i < 10; i++) regs[i] <= DEFAULTS[i*9 +: 9];
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
      scl_d <= scl_s;
      sda_d <= sda_s;
      o_reg_wr <= 1'b0;
      o_bad_reg <= 1'b0;
      o_soft_rst <= 1'b0;
      if (start) begin
        state <= ADDR;
        cnt <= '0;
        done <= 1'b0;
        o_sda_oe <= 1'b0;
        o_busy <= 1'b1;
      end else if (stop) begin
        state <= IDLE;
        o_sda_oe <= 1'b0;
        o_busy <= 1'b0;
      end else if (scl_rise && shifting) begin
        shreg <= {shreg[6:0], sda_s};
        cnt <= cnt + 3'd1;
        done <= cnt == 3'd7;
      end else if (scl_fall) begin
        case (state)
          ADDR: if (done) begin
            done <= 1'b0;
            state <= addr_ok ? ACK_A : IGNORE;
            o_sda_oe <= addr_ok;
          end
          BYTE1: if (done) begin
            done <= 1'b0;
            reg_a <= shreg[7:1];
            data_hi <= shreg[0];
            state <= ACK_1;
            o_sda_oe <= 1'b1;
          end
          BYTE2: if (done) begin
            done <= 1'b0;
            data_lo <= shreg;
            state <= ACK_2;
            o_sda_oe <= 1'b1;
          end
          ACK_A: begin
            state <= BYTE1;
            o_sda_oe <= 1'b0;
          end
          ACK_1: begin
            state <= BYTE2;
            o_sda_oe <= 1'b0;
          end
          ACK_2: begin
            state <= IGNORE;
            o_sda_oe <= 1'b0;
            o_reg_wr <= 1'b1;
            o_reg_addr <= reg_a;
            o_reg_data <= {data_hi, data_lo};
            if (reg_a < 7'd10) regs[reg_a[3:0]] <= {data_hi, data_lo};
            else if (reg_a == 7'h0F) begin
              o_soft_rst <= 1'b1;
              for (int i = 0; i < 10; i++) regs[i] <= DEFAULTS[i*9 +: 9];
            end else o_bad_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// tb_wm8731_i2c_responder: random I2C write frames checked against a frame-level register model
module tb_wm8731_i2c_responder;
  localparam int Q = 5;
  logic clk = 0, rst_n = 0, scl = 1, m_sda = 1;
  logic sda_oe, reg_wr, bad_reg, soft_rst, busy;
  logic [6:0] reg_addr;
  logic [8:0] reg_data, rd_data;
  logic [3:0] rd_addr = 0;
  wire sda_bus = m_sda & ~sda_oe;
  int errors = 0, checks = 0, wr_n = 0, bad_n = 0, soft_n = 0;
  logic [8:0] mregs [10];
  wm8731_i2c_responder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scl(scl), .i_sda(sda_bus),
    .o_sda_oe(sda_oe), .o_reg_wr(reg_wr), .o_reg_addr(reg_addr), .o_reg_data(reg_data),
    .o_bad_reg(bad_reg), .o_soft_rst(soft_rst), .o_busy(busy),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    wr_n += int'(reg_wr);
    bad_n += int'(bad_reg);
    soft_n += int'(soft_rst);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    mregs = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
  endtask
  task automatic check_regs();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr = 4'(i);
      #1;
      check($sformatf("rd%0d", i), 32'(rd_data), i < 10 ? 32'(mregs[i]) : 32'd0);
    end
  endtask
  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask
  task automatic i2c_start();
    m_sda = 1; wq(); scl = 1; wq(); m_sda = 0; wq(); scl = 0; wq();
  endtask
  task automatic i2c_stop();
    m_sda = 0; wq(); scl = 1; wq(); m_sda = 1; wq(); wq();
  endtask
  task automatic send_bits(input logic [7:0] b, output bit oe_seen);
    oe_seen = 0;
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; wq(); scl = 1; wq(); oe_seen |= sda_oe; wq(); scl = 0; wq();
    end
  endtask
  task automatic send_byte(input logic [7:0] b, output bit ack, output bit oe_seen);
    send_bits(b, oe_seen);
    m_sda = 1; wq(); scl = 1; wq(); ack = sda_oe; wq(); scl = 0; wq();
  endtask
  task automatic do_frame(input int n, input logic [7:0] b0, b1, b2, b3, input bit stop_it);
    logic [7:0] b [4];
    bit ack, oe_seen, commit;
    int w0, bd0, s0;
    logic [6:0] ra;
    logic [8:0] rd;
    b = '{b0, b1, b2, b3};
    w0 = wr_n; bd0 = bad_n; s0 = soft_n;
    i2c_start();
    for (int i = 0; i < n; i++) begin
      send_byte(b[i], ack, oe_seen);
      check($sformatf("ack%0d_%02h", i, b[i]), 32'(ack), 32'(b0 == 8'h34 && i < 3));
      check($sformatf("oe_data%0d", i), 32'(oe_seen), 0);
      if (i == 0) check("busy_frame", 32'(busy), 1);
    end
    if (stop_it) begin
      i2c_stop();
      check("busy_stop", 32'(busy), 0);
    end
    commit = b0 == 8'h34 && n >= 3;
    ra = b1[7:1];
    rd = {b1[0], b2};
    check("wr_cnt", 32'(wr_n - w0), 32'(commit));
    check("bad_cnt", 32'(bad_n - bd0), 32'(commit && ra > 9 && ra != 7'h0F));
    check("soft_cnt", 32'(soft_n - s0), 32'(commit && ra == 7'h0F));
    if (commit) begin
      check("reg_addr", 32'(reg_addr), 32'(ra));
      check("reg_data", 32'(reg_data), 32'(rd));
      if (ra == 7'h0F) model_reset();
      else if (ra < 10) mregs[ra] = rd;
    end
    check_regs();
  endtask
  initial begin
    bit ack, oe_seen;
    int w0, sel;
    logic [6:0] ra;
    logic [7:0] b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(reg_addr), 0);
    check("rst_data", 32'(reg_data), 0);
    check("rst_strobes", 32'({reg_wr, bad_reg, soft_rst}), 0);
    rst_n = 1;
    check_regs();
    do_frame(3, 8'h34, 8'h08, 8'h15, 8'h00, 1);
    do_frame(3, 8'h34, 8'h0D, 8'h67, 8'h00, 1);
    do_frame(3, 8'h34, 8'h1E, 8'h00, 8'h00, 1);
    do_frame(3, 8'h34, 8'h0D, 8'h67, 8'h00, 1);
    do_frame(3, 8'h36, 8'h08, 8'h55, 8'h00, 1);
    do_frame(3, 8'h35, 8'h08, 8'h55, 8'h00, 1);
    do_frame(4, 8'h34, 8'h14, 8'hAA, 8'hFF, 1);
    w0 = wr_n;
    i2c_start();
    send_byte(8'h34, ack, oe_seen);
    send_byte(8'h12, ack, oe_seen);
    do_frame(3, 8'h34, 8'h12, 8'h01, 8'h00, 1);
    check("rs_wr_total", 32'(wr_n - w0), 1);
    do_frame(2, 8'h34, 8'h12, 8'h00, 8'h00, 1);
    i2c_start();
    send_bits(8'h34, oe_seen);
    m_sda = 1; wq(); scl = 1; wq();
    check("oe_pre_rst", 32'(sda_oe), 1);
    rst_n = 0;
    #1;
    check("oe_async_rst", 32'(sda_oe), 0);
    check("busy_async_rst", 32'(busy), 0);
    wq();
    rst_n = 1;
    model_reset();
    scl = 0; wq();
    check_regs();
    do_frame(3, 8'h34, 8'h0A, 8'h3C, 8'h00, 1);
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 9);
      b0 = sel == 0 ? 8'h36 : sel == 1 ? 8'h35 : 8'h34;
      sel = $urandom_range(0, 7);
      ra = sel == 0 ? 7'h0F : sel == 1 ? 7'($urandom_range(10, 127)) : 7'($urandom_range(0, 9));
      sel = $urandom_range(0, 7);
      do_frame(sel == 0 ? 2 : sel == 1 ? 4 : 3, b0, {ra, 1'($urandom_range(0, 1))},
               8'($urandom), 8'($urandom), 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
